// File: rtl/reaction_pkg.sv
// Shared state encoding, widths and constants for the reaction-timer game controller.
// Pure declarations: no latency, no flow control.
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      LIT,
      REQ,
      ACK_LO
   } state_t;

   localparam int          TICKS_PER_MS_DEF = 50000;
   localparam int          MS_W             = 10;
   localparam logic [7:0]  LEDS_OFF         = 8'h00;
   localparam logic [7:0]  LEDS_ON          = 8'hFF;
   localparam logic [15:0] LFSR_SEED        = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS        = 16'hB400;

   // Right-shifting Galois step for x^16 + x^14 + x^13 + x^11 + 1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit maximal-length Galois LFSR; advances every cycle, never reaches zero.
// One-cycle register latency, no backpressure.
module lfsr16
   import reaction_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   output logic [15:0] lfsr
);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) lfsr <= LFSR_SEED;
      else      lfsr <= lfsr_next(lfsr);
   end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction game controller: random delay, LED stimulus, ms reaction timing, four-phase LCD request.
// React edge -> LCDUpdate in 2 cycles; each message is held until LCDAck completes the handshake.
module reaction_timer_ctrl
   import reaction_pkg::*;
#(
   parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
   parameter int MAX_MS       = 1000,
   parameter int DELAY_MIN_MS = 1000,
   parameter int DELAY_BITS   = 10
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            Start,
   input  logic            React,
   output logic [7:0]      LEDs,
   output logic            Cheat,
   output logic            Slow,
   output logic            Wait,
   output logic [MS_W-1:0] ReactionTime,
   output logic            LCDUpdate,
   input  logic            LCDAck
);

   localparam int DLY_W  = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS));
   localparam int CNT_W  = (DLY_W > MS_W) ? DLY_W : MS_W;
   localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);
   localparam logic [CNT_W-1:0]  MS_LIMIT  = CNT_W'(MAX_MS);
   localparam logic [MS_W-1:0]   RT_SAT    = MS_W'(MAX_MS - 1);

   state_t            state;
   logic [TICK_W-1:0] tick_cnt;
   logic [CNT_W-1:0]  ms_cnt;
   logic [CNT_W-1:0]  delay_ms;
   logic [MS_W-1:0]   rt_now;
   logic [15:0]       lfsr;
   logic              lfsr_unused;
   logic              start_prev, react_prev;
   logic              start_edge, react_edge;

   lfsr16 u_lfsr (
      .Clk  (Clk),
      .Rst  (Rst),
      .lfsr (lfsr)
   );

   assign lfsr_unused = ^lfsr[15:DELAY_BITS];

   // Previous values reset high so a button held through reset never counts as a press.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         start_prev <= 1'b1;
         react_prev <= 1'b1;
         start_edge <= 1'b0;
         react_edge <= 1'b0;
      end else begin
         start_prev <= Start;
         react_prev <= React;
         start_edge <= Start & ~start_prev;
         react_edge <= React & ~react_prev;
      end
   end

   always_comb begin
      rt_now = ms_cnt[MS_W-1:0];
      if (ms_cnt >= MS_LIMIT) rt_now = RT_SAT;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         ms_cnt       <= '0;
         delay_ms     <= '0;
         LEDs         <= LEDS_OFF;
         Cheat        <= 1'b0;
         Slow         <= 1'b0;
         Wait         <= 1'b0;
         ReactionTime <= '0;
         LCDUpdate    <= 1'b0;
      end else begin
         // Free-running ms timebase; every state transition below restarts it from zero.
         if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (ms_cnt != '1) ms_cnt <= ms_cnt + CNT_W'(1);
         end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
         end

         case (state)
            IDLE: if (start_edge) begin
               delay_ms     <= CNT_W'(DELAY_MIN_MS) + CNT_W'(lfsr[DELAY_BITS-1:0]);
               Cheat        <= 1'b0;
               Slow         <= 1'b0;
               Wait         <= 1'b1;
               ReactionTime <= '0;
               LCDUpdate    <= 1'b1;
               state        <= REQ;
               tick_cnt     <= '0;
               ms_cnt       <= '0;
            end
            DELAY: if (react_edge) begin
               Cheat        <= 1'b1;
               Slow         <= 1'b0;
               Wait         <= 1'b0;
               ReactionTime <= '0;
               LCDUpdate    <= 1'b1;
               state        <= REQ;
               tick_cnt     <= '0;
               ms_cnt       <= '0;
            end else if (ms_cnt == delay_ms) begin
               LEDs     <= LEDS_ON;
               state    <= LIT;
               tick_cnt <= '0;
               ms_cnt   <= '0;
            end
            LIT: if (react_edge || ms_cnt >= MS_LIMIT) begin
               Cheat        <= 1'b0;
               Slow         <= !react_edge;
               Wait         <= 1'b0;
               ReactionTime <= react_edge ? rt_now : RT_SAT;
               LCDUpdate    <= 1'b1;
               state        <= REQ;
               tick_cnt     <= '0;
               ms_cnt       <= '0;
            end
            REQ: if (LCDAck) begin
               LCDUpdate <= 1'b0;
               state     <= ACK_LO;
               tick_cnt  <= '0;
               ms_cnt    <= '0;
            end
            ACK_LO: if (!LCDAck) begin
               tick_cnt <= '0;
               ms_cnt   <= '0;
               if (Wait) begin
                  state <= DELAY;
               end else begin
                  LEDs  <= LEDS_OFF;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
